// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: owns the PC, fetches 8-bit instructions over a
// req/ack handshake, holds decoded fields during execution and selects the next PC.
`ifndef OP
`define OP 4
`endif
`ifndef ADD
`define ADD 4'h1
`endif
`ifndef JI
`define JI 4'hC
`endif

module fetch_unit #(
  parameter int OP = `OP,
  parameter int ADDR = 8,
  parameter logic [ADDR-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [ADDR-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [7:0]      imem_data,
  output logic [OP-1:0]   op,
  output logic [1:0]      ra,
  output logic [1:0]      rb,
  output logic [3:0]      imm,
  output logic            instr_valid,
  input  logic            exec_done,
  input  logic            redirect,
  input  logic [ADDR-1:0] redirect_pc,
  output logic [ADDR-1:0] pc
);

  typedef enum logic {FETCH, ISSUE} state_t;

  state_t          state_reg;
  logic [ADDR-1:0] pc_reg;
  logic [7:0]      ir_reg;
  logic            req_reg;
  logic            valid_reg;
  logic [ADDR-1:0] next_pc;
  logic [3:0]      ir_op;

  assign ir_op = ir_reg[7:4];

  // JI offset is relative to the JI instruction's own address (the current pc).
  always_comb begin
    next_pc = pc_reg + {{(ADDR-1){1'b0}}, 1'b1};
    if (redirect)
      next_pc = redirect_pc;
    else if (ir_op == `JI)
      next_pc = pc_reg + {{(ADDR-4){ir_reg[3]}}, ir_reg[3:0]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= FETCH;
      pc_reg    <= RESET_PC;
      ir_reg    <= '0;
      req_reg   <= 1'b0;
      valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        FETCH: begin
          // The request only starts being visible one cycle after reset, so an ack
          // counts only while it is actually asserted.
          if (req_reg && imem_ack) begin
            ir_reg    <= imem_data;
            req_reg   <= 1'b0;
            valid_reg <= 1'b1;
            state_reg <= ISSUE;
          end else begin
            req_reg <= 1'b1;
          end
        end
        ISSUE: begin
          if (exec_done) begin
            pc_reg    <= next_pc;
            valid_reg <= 1'b0;
            req_reg   <= 1'b1;
            state_reg <= FETCH;
          end
        end
        default: state_reg <= FETCH;
      endcase
    end
  end

  assign imem_req    = req_reg;
  assign imem_addr   = pc_reg;
  assign pc          = pc_reg;
  assign op          = OP'(ir_reg[7:4]);
  assign ra          = ir_reg[3:2];
  assign rb          = ir_reg[1:0];
  assign imm         = ir_reg[3:0];
  assign instr_valid = valid_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: reset, variable-latency fetch,
// JI wrap/forward, redirect priority, ignored inputs and reset mid-wait.
`ifndef OP
`define OP 4
`endif
`ifndef ADD
`define ADD 4'h1
`endif
`ifndef JI
`define JI 4'hC
`endif

module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_ack;
  logic [7:0] imem_data;
  logic [3:0] op;
  logic [1:0] ra;
  logic [1:0] rb;
  logic [3:0] imm;
  logic       instr_valid;
  logic       exec_done;
  logic       redirect;
  logic [7:0] redirect_pc;
  logic [7:0] pc;

  int n_checks = 0;
  int n_fail = 0;

  fetch_unit #(.OP(4), .ADDR(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data),
    .op(op), .ra(ra), .rb(rb), .imm(imm),
    .instr_valid(instr_valid),
    .exec_done(exec_done), .redirect(redirect), .redirect_pc(redirect_pc),
    .pc(pc)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic give_instr(input logic [7:0] data);
    imem_ack  = 1'b1;
    imem_data = data;
    tick();
    imem_ack  = 1'b0;
    imem_data = 8'h00;
  endtask

  task automatic finish_instr(input logic redir, input logic [7:0] rpc);
    exec_done   = 1'b1;
    redirect    = redir;
    redirect_pc = rpc;
    tick();
    exec_done   = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 8'h00;
  endtask

  task automatic check_fetch(input string tag, input logic [7:0] exp_pc);
    check_val({tag, " pc"}, 32'(pc), 32'(exp_pc));
    check_val({tag, " req"}, 32'(imem_req), 32'd1);
    check_val({tag, " addr"}, 32'(imem_addr), 32'(exp_pc));
    check_val({tag, " valid"}, 32'(instr_valid), 32'd0);
  endtask

  initial begin
    logic [3:0] add_op;
    logic [3:0] ji_op;
    add_op      = `ADD;
    ji_op       = `JI;
    rst         = 1'b1;
    imem_ack    = 1'b0;
    imem_data   = 8'h00;
    exec_done   = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 8'h00;

    // Reset held for two cycles
    tick();
    tick();
    check_val("rst pc", 32'(pc), 32'h00);
    check_val("rst valid", 32'(instr_valid), 32'd0);
    check_val("rst req", 32'(imem_req), 32'd0);
    check_val("rst op", 32'(op), 32'd0);
    rst = 1'b0;
    tick();
    check_fetch("first fetch", 8'h00);

    // Zero-wait ADD
    give_instr({add_op, 4'h5});
    check_val("add0 valid", 32'(instr_valid), 32'd1);
    check_val("add0 op", 32'(op), 32'(add_op));
    check_val("add0 ra", 32'(ra), 32'd1);
    check_val("add0 rb", 32'(rb), 32'd1);
    check_val("add0 req", 32'(imem_req), 32'd0);
    finish_instr(1'b0, 8'h00);
    check_fetch("seq1", 8'h01);

    // Three-cycle wait, address held
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("wait addr", 32'(imem_addr), 32'h01);
      check_val("wait req", 32'(imem_req), 32'd1);
    end
    give_instr({add_op, 4'h5});
    check_val("add1 valid", 32'(instr_valid), 32'd1);
    check_val("add1 op", 32'(op), 32'(add_op));
    finish_instr(1'b0, 8'h00);
    check_fetch("seq2", 8'h02);

    // Redirect back to 0x01 to set up the backward JI
    give_instr({add_op, 4'h0});
    finish_instr(1'b1, 8'h01);
    check_fetch("redir 01", 8'h01);

    // JI -2 at 0x01, with stray redirect and spurious ack while issuing
    give_instr({ji_op, 4'hE});
    check_val("ji back op", 32'(op), 32'(ji_op));
    redirect    = 1'b1;
    redirect_pc = 8'h55;
    tick();
    redirect    = 1'b0;
    redirect_pc = 8'h00;
    check_val("stray redir pc", 32'(pc), 32'h01);
    check_val("stray redir valid", 32'(instr_valid), 32'd1);
    give_instr(8'h3A);
    check_val("spur ack op", 32'(op), 32'(ji_op));
    check_val("spur ack imm", 32'(imm), 32'hE);
    check_val("spur ack valid", 32'(instr_valid), 32'd1);
    finish_instr(1'b0, 8'h00);
    check_fetch("ji wrap", 8'hFF);

    // Move to 0x10, then JI +7
    give_instr({add_op, 4'h0});
    finish_instr(1'b1, 8'h10);
    check_fetch("redir 10", 8'h10);
    give_instr({ji_op, 4'h7});
    finish_instr(1'b0, 8'h00);
    check_fetch("ji fwd", 8'h17);

    // Redirect wins over the JI target (0x17+3)
    give_instr({ji_op, 4'h3});
    finish_instr(1'b1, 8'h40);
    check_fetch("redir prio", 8'h40);

    // Reset while waiting for an ack
    tick();
    rst = 1'b1;
    tick();
    check_val("midrst req", 32'(imem_req), 32'd0);
    check_val("midrst pc", 32'(pc), 32'h00);
    check_val("midrst valid", 32'(instr_valid), 32'd0);
    check_val("midrst op", 32'(op), 32'd0);
    rst = 1'b0;
    tick();
    check_fetch("refetch", 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch sequencer for the REDUX-V core: it is the producer side of the opcode interface that `control_unit` decodes. It owns the program counter, reads 8-bit instructions from instruction memory through a req/ack handshake, and holds the decoded fields (`op`, `ra`, `rb`, `imm`) stable while the datapath executes. It then computes the next PC as sequential, `JI`-relative, or datapath-redirected.

## Interface
- `OP`, default `` `OP `` (4): opcode width, equal to `control_unit` `OP`.
- `ADDR`, default 8: PC and instruction-memory address width.
- `RESET_PC`, default 0: PC value loaded on reset.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `imem_req` out 1: read request to instruction memory.
- `imem_addr` out `ADDR`: read address; equals `pc` whenever `imem_req`=1.
- `imem_ack` in 1: read data valid.
- `imem_data` in 8: instruction word; `{op[3:0], ra[1:0], rb[1:0]}`.
- `op` out `OP`: to `control_unit.op`; `imem_data[7:4]` of the current instruction.
- `ra` out 2 and `rb` out 2: register fields `imem_data[3:2]` and `[1:0]`.
- `imm` out 4: `imem_data[3:0]`, for `ADDI`/`JI`.
- `instr_valid` out 1: `op`/`ra`/`rb`/`imm` hold a fetched instruction under execution.
- `exec_done` in 1: datapath has finished the current instruction.
- `redirect` in 1: the datapath asserts this with `exec_done` for a taken `BRZR`.
- `redirect_pc` in `ADDR`: branch target; sampled only when `exec_done` and `redirect` are both 1.
- `pc` out `ADDR`: address of the current or pending instruction.

## Operation
- Two-state FSM: FETCH and ISSUE.
- Reset values:
  - State becomes FETCH.
  - `pc`=`RESET_PC`.
  - The instruction register is cleared, so `op`=`ra`=`rb`=`imm`=0.
  - `instr_valid`=0.
  - `imem_req`=0 in the reset cycle.
- FETCH:
  - `imem_req`=1 and `imem_addr`=`pc`, both held constant until `imem_ack`.
  - On `imem_ack`=1, `imem_data` is captured into the instruction register and the state moves to ISSUE.
  - `exec_done` and `redirect` are ignored in FETCH.
- ISSUE:
  - `instr_valid`=1, `imem_req`=0.
  - The instruction fields and `pc` are held stable.
  - `imem_ack` is ignored in ISSUE.
  - On `exec_done`=1, the next PC is loaded, `instr_valid` drops, and the state returns to FETCH.
- Next-PC priority, evaluated on `exec_done` in ISSUE:
  1. If `redirect`=1: `pc` ← `redirect_pc`.
  2. Else if `op`==`` `JI ``: `pc` ← `pc` + sign-extend(`imm`). `imm` is two's complement in the range -8..+7, and the offset is relative to the `JI` instruction's own address.
  3. Otherwise: `pc` ← `pc` + 1.
- Arithmetic is modulo 2^`ADDR`; wrap-around in either direction is legal and silent.
- The `JI` target is computed locally. `control_unit` still raises `J` for the datapath, but the datapath does not drive `redirect` for `JI`.
- `redirect` asserted without `exec_done` has no effect.
- Reset mid-operation, in either state, aborts any outstanding request without waiting for `imem_ack`. Instruction memory shares `rst` and must drop a pending ack on reset.

## Timing
- Fetch latency: FETCH is entered at cycle t with `imem_req`=1. If `imem_ack` arrives at cycle t+k (k≥0), `instr_valid`=1 from cycle t+k+1.
- Zero-wait memory (ack in the same cycle as req) gives the minimum loop: FETCH, ISSUE, then FETCH again on the cycle after `exec_done`. This is 2 cycles per instruction when `exec_done` is asserted in the first ISSUE cycle.
- `exec_done` in cycle u means:
  - `instr_valid`=0 and the new `pc` is visible at u+1.
  - `imem_req`=1 with the new address at u+1.
- `rst` asserted at cycle r means all outputs take their reset values at r+1. The first `imem_req` appears the cycle after `rst` deasserts.
- All outputs are registered; there is no combinational path from any input to any output.

## Test plan
- **Reset and first fetch.** Assert `rst` for 2 cycles, then release it. Required: `pc`=0x00, `instr_valid`=0, and `imem_req`=1 with `imem_addr`=0x00 on the first cycle after release.
- **Sequential flow with variable latency.** Memory returns `ADD`(0x?5) after a 0-cycle wait and a 3-cycle wait. Required:
  - `imem_addr` is held during the wait.
  - `op`=`` `ADD `` and `instr_valid`=1 one cycle after the ack.
  - After `exec_done`, `pc`=0x01 and then 0x02.
- **`JI` backward with wrap.** At `pc`=0x01, execute `JI` with `imm`=0xE (-2). Required: next `pc`=0xFF, and `imem_addr`=0xFF is requested.
- **`JI` forward.** At `pc`=0x10, execute `JI` with `imm`=0x7. Required: next `pc`=0x17.
- **`BRZR` redirect priority.** Redirect over a `JI` instruction: pulse `redirect`=1 with `redirect_pc`=0x40 together with `exec_done`. Required: `pc`=0x40, not the `JI` target.
- **Ignored inputs.** Stray `redirect`=1 without `exec_done` in ISSUE: required, no PC change. Spurious `imem_ack` in ISSUE: required, fields unchanged.
- **Reset mid-wait.** Assert `rst` while `imem_req`=1 and before the ack. Required: `imem_req`=0 and `pc`=0x00 next cycle, and the fetch restarts at 0x00.
